// File: rtl/intersection_phase_scheduler.sv
// NS/EW intersection phase sequencer: skips undemanded left turns, grants latched walks, preempts to all-red.
// Outputs are registered state decode (no extra latency); there is no backpressure.
module intersection_phase_scheduler #(
  parameter int LEFT_CYC   = 4,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int CLEAR_CYC  = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emergency,
  input  logic       left_req_ns,
  input  logic       left_req_ew,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  output logic       LeftTurn_NS,
  output logic       Green_NS,
  output logic       Yellow_NS,
  output logic       Red_NS,
  output logic       LeftTurn_EW,
  output logic       Green_EW,
  output logic       Yellow_EW,
  output logic       Red_EW,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [3:0] phase
);

  localparam logic [3:0] S_CLR_EW  = 4'd0;
  localparam logic [3:0] S_NS_LEFT = 4'd1;
  localparam logic [3:0] S_NS_GRN  = 4'd2;
  localparam logic [3:0] S_NS_YEL  = 4'd3;
  localparam logic [3:0] S_CLR_NS  = 4'd4;
  localparam logic [3:0] S_EW_LEFT = 4'd5;
  localparam logic [3:0] S_EW_GRN  = 4'd6;
  localparam logic [3:0] S_EW_YEL  = 4'd7;
  localparam logic [3:0] S_EMERG   = 4'd8;

  localparam logic [CNT_W-1:0] LEFT_LD = CNT_W'(LEFT_CYC - 1);
  localparam logic [CNT_W-1:0] GRN_LD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YEL_LD  = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD  = CNT_W'(CLEAR_CYC - 1);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             left_pend_ns_q, left_pend_ew_q;
  logic             ped_pend_ns_q, ped_pend_ew_q;
  logic             emerg_seen_q;
  logic             walk_ns_q, walk_ew_q;
  logic             cnt_done;
  logic             next_in_ring;
  logic             enter_ns_left, enter_ew_left, enter_ns_grn, enter_ew_grn;

  assign cnt_done = (cnt_q == '0);

  function automatic logic [CNT_W-1:0] load_of(input logic [3:0] s);
    case (s)
      S_NS_LEFT, S_EW_LEFT: load_of = LEFT_LD;
      S_NS_GRN,  S_EW_GRN:  load_of = GRN_LD;
      S_NS_YEL,  S_EW_YEL:  load_of = YEL_LD;
      default:              load_of = CLR_LD;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLR_EW: begin
        if (emergency)     state_d = S_EMERG;
        else if (cnt_done) state_d = left_pend_ns_q ? S_NS_LEFT : S_NS_GRN;
      end
      S_NS_LEFT: begin
        if (emergency)     state_d = S_NS_YEL;
        else if (cnt_done) state_d = S_NS_GRN;
      end
      S_NS_GRN: begin
        if (emergency || cnt_done) state_d = S_NS_YEL;
      end
      // Emergency seen during the ring diverts the end of yellow to EMERG.
      S_NS_YEL: begin
        if (cnt_done) state_d = (emerg_seen_q || emergency) ? S_EMERG : S_CLR_NS;
      end
      S_CLR_NS: begin
        if (emergency)     state_d = S_EMERG;
        else if (cnt_done) state_d = left_pend_ew_q ? S_EW_LEFT : S_EW_GRN;
      end
      S_EW_LEFT: begin
        if (emergency)     state_d = S_EW_YEL;
        else if (cnt_done) state_d = S_EW_GRN;
      end
      S_EW_GRN: begin
        if (emergency || cnt_done) state_d = S_EW_YEL;
      end
      S_EW_YEL: begin
        if (cnt_done) state_d = (emerg_seen_q || emergency) ? S_EMERG : S_CLR_EW;
      end
      S_EMERG: begin
        if (!emergency && cnt_done) state_d = left_pend_ns_q ? S_NS_LEFT : S_NS_GRN;
      end
      default: state_d = S_CLR_EW;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (state_d != state_q)                     cnt_d = load_of(state_d);
    else if (state_q == S_EMERG && emergency)   cnt_d = CLR_LD;
  end

  always_comb begin
    next_in_ring = 1'b0;
    case (state_d)
      S_NS_LEFT, S_NS_GRN, S_NS_YEL,
      S_EW_LEFT, S_EW_GRN, S_EW_YEL: next_in_ring = 1'b1;
      default:                       next_in_ring = 1'b0;
    endcase
  end

  assign enter_ns_left = (state_d == S_NS_LEFT) && (state_q != S_NS_LEFT);
  assign enter_ew_left = (state_d == S_EW_LEFT) && (state_q != S_EW_LEFT);
  assign enter_ns_grn  = (state_d == S_NS_GRN)  && (state_q != S_NS_GRN);
  assign enter_ew_grn  = (state_d == S_EW_GRN)  && (state_q != S_EW_GRN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_CLR_EW;
      cnt_q          <= CLR_LD;
      left_pend_ns_q <= 1'b0;
      left_pend_ew_q <= 1'b0;
      ped_pend_ns_q  <= 1'b0;
      ped_pend_ew_q  <= 1'b0;
      emerg_seen_q   <= 1'b0;
      walk_ns_q      <= 1'b0;
      walk_ew_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      // A request on the clearing edge keeps the latch set.
      left_pend_ns_q <= left_req_ns | (left_pend_ns_q & ~enter_ns_left);
      left_pend_ew_q <= left_req_ew | (left_pend_ew_q & ~enter_ew_left);
      ped_pend_ns_q  <= ped_req_ns  | (ped_pend_ns_q  & ~enter_ns_grn);
      ped_pend_ew_q  <= ped_req_ew  | (ped_pend_ew_q  & ~enter_ew_grn);
      emerg_seen_q   <= next_in_ring & (emerg_seen_q | emergency);
      walk_ns_q      <= (state_d == S_NS_GRN) & (enter_ns_grn ? ped_pend_ns_q : walk_ns_q);
      walk_ew_q      <= (state_d == S_EW_GRN) & (enter_ew_grn ? ped_pend_ew_q : walk_ew_q);
    end
  end

  always_comb begin
    LeftTurn_NS = (state_q == S_NS_LEFT);
    Green_NS    = (state_q == S_NS_GRN);
    Yellow_NS   = (state_q == S_NS_YEL);
    Red_NS      = !(LeftTurn_NS || Green_NS || Yellow_NS);
    LeftTurn_EW = (state_q == S_EW_LEFT);
    Green_EW    = (state_q == S_EW_GRN);
    Yellow_EW   = (state_q == S_EW_YEL);
    Red_EW      = !(LeftTurn_EW || Green_EW || Yellow_EW);
  end

  assign walk_ns = walk_ns_q;
  assign walk_ew = walk_ew_q;
  assign phase   = state_q;

endmodule
